// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared state encoding and frame constants for the imem loader
package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN0,
    ST_LEN1,
    ST_DATA,
    ST_CSUM,
    ST_RUN,
    ST_ERR
  } state_e;

  localparam int BYTES_PER_WORD = 4;
  localparam int LEN_BYTES      = 2;

  // States in which the loader is consuming stream bytes.
  function automatic logic is_rx_state(input state_e s);
    return (s == ST_LEN0) || (s == ST_LEN1) || (s == ST_DATA) || (s == ST_CSUM);
  endfunction

endpackage

// File: rtl/imem_loader_ram.sv
// rtl/imem_loader_ram.sv - DEPTH x 32 instruction RAM, sync write, async read, no reset
module imem_ram #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [31:0]       wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [31:0]       rdata
);

  logic [31:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream program loader holding the CPU in reset, plus fetch port
// Optional trailing XOR checksum byte is enabled by defining IMEM_CHECKSUM_EN.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  input  logic [31:0] pc,
  output logic [31:0] instr,
  output logic        cpu_reset,
  output logic        load_done,
  output logic        load_err
);

  localparam logic [ADDR_W:0] WORD_ONE = {{ADDR_W{1'b0}}, 1'b1};

`ifdef IMEM_CHECKSUM_EN
  localparam state_e PAYLOAD_DONE = ST_CSUM;
`else
  localparam state_e PAYLOAD_DONE = ST_RUN;
`endif

  state_e          state_q, state_d;
  logic [7:0]      len_lo_q, len_lo_d;
  logic [ADDR_W:0] len_q, len_d;
  logic [ADDR_W:0] word_cnt_q, word_cnt_d;
  logic [1:0]      byte_cnt_q, byte_cnt_d;
  logic [23:0]     word_buf_q, word_buf_d;
`ifdef IMEM_CHECKSUM_EN
  logic [7:0]      csum_q, csum_d;
`endif

  logic            accept;
  logic [15:0]     len_full;
  logic            ram_we;
  logic [31:0]     ram_wdata;
  logic            unused_pc_bits;

  assign accept    = rx_valid & rx_ready;
  assign len_full  = {rx_data, len_lo_q};
  assign ram_wdata = {rx_data, word_buf_q};

  always_comb begin
    state_d    = state_q;
    len_lo_d   = len_lo_q;
    len_d      = len_q;
    word_cnt_d = word_cnt_q;
    byte_cnt_d = byte_cnt_q;
    word_buf_d = word_buf_q;
`ifdef IMEM_CHECKSUM_EN
    csum_d     = csum_q;
`endif
    ram_we     = 1'b0;

    // A restart wins over any byte arriving on the same edge.
    if (load_start) begin
      state_d    = ST_LEN0;
      word_cnt_d = '0;
      byte_cnt_d = '0;
`ifdef IMEM_CHECKSUM_EN
      csum_d     = '0;
`endif
    end else if (accept) begin
      case (state_q)
        ST_LEN0: begin
          len_lo_d = rx_data;
          state_d  = ST_LEN1;
        end
        ST_LEN1: begin
          len_d = len_full[ADDR_W:0];
          if (len_full > 16'(DEPTH)) begin
            state_d = ST_ERR;
          end else if (len_full == 16'd0) begin
            state_d = PAYLOAD_DONE;
          end else begin
            state_d = ST_DATA;
          end
        end
        ST_DATA: begin
`ifdef IMEM_CHECKSUM_EN
          csum_d = csum_q ^ rx_data;
`endif
          byte_cnt_d = byte_cnt_q + 2'd1;
          case (byte_cnt_q)
            2'd0:    word_buf_d[7:0]   = rx_data;
            2'd1:    word_buf_d[15:8]  = rx_data;
            2'd2:    word_buf_d[23:16] = rx_data;
            default: word_buf_d        = word_buf_q;
          endcase
          if (byte_cnt_q == 2'(BYTES_PER_WORD - 1)) begin
            ram_we     = 1'b1;
            word_cnt_d = word_cnt_q + WORD_ONE;
            if ((word_cnt_q + WORD_ONE) == len_q) begin
              state_d = PAYLOAD_DONE;
            end
          end
        end
`ifdef IMEM_CHECKSUM_EN
        ST_CSUM: begin
          state_d = (rx_data == csum_q) ? ST_RUN : ST_ERR;
        end
`endif
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      len_lo_q   <= '0;
      len_q      <= '0;
      word_cnt_q <= '0;
      byte_cnt_q <= '0;
      word_buf_q <= '0;
`ifdef IMEM_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      len_lo_q   <= len_lo_d;
      len_q      <= len_d;
      word_cnt_q <= word_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      word_buf_q <= word_buf_d;
`ifdef IMEM_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  // Handshake and CPU control decode from state alone, never from rx_valid.
  assign rx_ready  = is_rx_state(state_q);
  assign cpu_reset = (state_q != ST_RUN);
  assign load_done = (state_q == ST_RUN);
  assign load_err  = (state_q == ST_ERR);

  assign unused_pc_bits = ^{pc[31:ADDR_W+2], pc[1:0]};

  imem_ram #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .waddr(word_cnt_q[ADDR_W-1:0]),
    .wdata(ram_wdata),
    .raddr(pc[ADDR_W+1:2]),
    .rdata(instr)
  );

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - randomized self-checking bench for imem_loader against a frame-level model
module tb_imem_loader;

  localparam int DEPTH  = 64;
  localparam int M_BUSY = 0;
  localparam int M_RUN  = 1;
  localparam int M_ERR  = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        cpu_reset;
  logic        load_done;
  logic        load_err;

  int          n_vec = 0;
  int          n_err = 0;
  logic        tog = 1'b0;

  logic [7:0]  cur_frame[$];
  logic [7:0]  fq[$];
  logic [31:0] ref_mem [DEPTH];
  bit          ref_valid [DEPTH];

  imem_loader #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .load_start(load_start),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .pc        (pc),
    .instr     (instr),
    .cpu_reset (cpu_reset),
    .load_done (load_done),
    .load_err  (load_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int model_status(input logic [7:0] q[$]);
    int n;
    int need;
    logic [7:0] x;
    if (q.size() < 2) return M_BUSY;
    n = int'(q[0]) + 256 * int'(q[1]);
    if (n > DEPTH) return M_ERR;
    need = 2 + 4 * n;
`ifdef IMEM_CHECKSUM_EN
    need = need + 1;
    if (q.size() < need) return M_BUSY;
    x = 8'h00;
    for (int k = 2; k < need - 1; k++) x = x ^ q[k];
    return (x == q[need-1]) ? M_RUN : M_ERR;
`else
    x = 8'h00;
    if (q.size() < need) return M_BUSY;
    return (x == 8'h00) ? M_RUN : M_ERR;
`endif
  endfunction

  task automatic update_ref(input logic [7:0] q[$]);
    int n;
    if (q.size() < 2) return;
    n = int'(q[0]) + 256 * int'(q[1]);
    if (n > DEPTH) return;
    for (int w = 0; w < n; w++) begin
      if (2 + 4 * w + 3 < q.size()) begin
        ref_mem[w]   = {q[5+4*w], q[4+4*w], q[3+4*w], q[2+4*w]};
        ref_valid[w] = 1'b1;
      end
    end
  endtask

  task automatic check_status(input string tag);
    int st;
    st = model_status(cur_frame);
    chk({tag, ".rx_ready"},  {31'd0, rx_ready},  {31'd0, st == M_BUSY});
    chk({tag, ".cpu_reset"}, {31'd0, cpu_reset}, {31'd0, st != M_RUN});
    chk({tag, ".load_done"}, {31'd0, load_done}, {31'd0, st == M_RUN});
    chk({tag, ".load_err"},  {31'd0, load_err},  {31'd0, st == M_ERR});
  endtask

  task automatic start_load();
    @(negedge clk);
    load_start = 1'b1;
    rx_valid   = 1'($urandom_range(0, 1));
    rx_data    = 8'($urandom);
    @(posedge clk);
    #1;
    cur_frame.delete();
    load_start = 1'b0;
    rx_valid   = 1'b0;
    chk("start.rx_ready",  {31'd0, rx_ready},  32'd1);
    chk("start.cpu_reset", {31'd0, cpu_reset}, 32'd1);
    chk("start.load_done", {31'd0, load_done}, 32'd0);
    chk("start.load_err",  {31'd0, load_err},  32'd0);
  endtask

  // density 0 toggles rx_valid every cycle; otherwise percent chance of valid.
  task automatic send_bytes(input logic [7:0] q[$], input int density);
    bit ok;
    int budget;
    for (int i = 0; i < q.size(); i++) begin
      budget = 0;
      ok = 1'b0;
      while (!ok && budget < 400) begin
        @(negedge clk);
        rx_data  = q[i];
        rx_valid = (density == 0) ? tog : ($urandom_range(1, 100) <= density);
        tog      = ~tog;
        ok       = rx_valid && rx_ready;
        @(posedge clk);
        budget++;
      end
      if (!ok) begin
        chk("accept_timeout", 32'd0, 32'd1);
        break;
      end
      #1;
      cur_frame.push_back(q[i]);
      update_ref(cur_frame);
      check_status("byte");
    end
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic fetch_check();
    for (int w = 0; w < DEPTH; w++) begin
      if (ref_valid[w]) begin
        pc = 32'($urandom_range(0, 15) * DEPTH * 4 + w * 4 + $urandom_range(0, 3));
        #1;
        chk("fetch", instr, ref_mem[w]);
      end
    end
  endtask

  task automatic make_random_frame(input int n, input bit good);
    logic [7:0] x;
    fq.delete();
    fq.push_back(8'(n));
    fq.push_back(8'(n >> 8));
    if (n > DEPTH) return;
    x = 8'h00;
    for (int k = 0; k < 4 * n; k++) begin
      fq.push_back(8'($urandom));
      x = x ^ fq[fq.size()-1];
    end
`ifdef IMEM_CHECKSUM_EN
    fq.push_back(good ? x : (x ^ 8'($urandom_range(1, 255))));
`else
    if (good) x = 8'h00;
`endif
  endtask

  task automatic directed_frame();
    fq = '{8'h02, 8'h00, 8'h20, 8'h00, 8'h08, 8'h20, 8'h05, 8'h00, 8'h09, 8'h20};
`ifdef IMEM_CHECKSUM_EN
    fq.push_back(8'h24);
`endif
  endtask

  initial begin
    int n;
    int cut;
    bit good;
    reset      = 1'b1;
    load_start = 1'b0;
    rx_data    = 8'h5A;
    rx_valid   = 1'b1;
    pc         = 32'd0;
    for (int w = 0; w < DEPTH; w++) ref_valid[w] = 1'b0;

    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("reset.cpu_reset", {31'd0, cpu_reset}, 32'd1);
      chk("reset.rx_ready",  {31'd0, rx_ready},  32'd0);
      chk("reset.load_done", {31'd0, load_done}, 32'd0);
      chk("reset.load_err",  {31'd0, load_err},  32'd0);
    end
    reset    = 1'b0;
    rx_valid = 1'b0;

    directed_frame();
    start_load();
    send_bytes(fq, 100);
    check_status("dir");
    pc = 32'h0;   #1; chk("dir.pc0",    instr, 32'h20080020);
    pc = 32'h4;   #1; chk("dir.pc4",    instr, 32'h20090005);
    pc = 32'h104; #1; chk("dir.pc104",  instr, 32'h20090005);

    directed_frame();
    start_load();
    send_bytes(fq, 0);
    check_status("toggle");
    fetch_check();
    pc = 32'h4;   #1; chk("toggle.pc4", instr, 32'h20090005);

    fq = '{8'h41, 8'h00};
    start_load();
    send_bytes(fq, 100);
    check_status("oversize");
    chk("oversize.load_err", {31'd0, load_err}, 32'd1);

`ifdef IMEM_CHECKSUM_EN
    directed_frame();
    fq[fq.size()-1] = 8'h25;
    start_load();
    send_bytes(fq, 100);
    check_status("badcsum");
    chk("badcsum.load_err", {31'd0, load_err}, 32'd1);
`endif

    fq = '{8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    start_load();
    send_bytes(fq, 100);
    fq = '{8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
`ifdef IMEM_CHECKSUM_EN
    fq.push_back(8'hAA ^ 8'hBB ^ 8'hCC ^ 8'hDD);
`endif
    start_load();
    send_bytes(fq, 70);
    check_status("abort");
    pc = 32'h0; #1; chk("abort.ram0", instr, 32'hDDCCBBAA);
    pc = 32'h4; #1; chk("abort.ram1", instr, 32'h20090005);

    for (int r = 0; r < 14; r++) begin
      n    = ($urandom_range(0, 5) == 0) ? $urandom_range(DEPTH + 1, 300) : $urandom_range(0, DEPTH);
      good = ($urandom_range(0, 4) != 0);
      make_random_frame(n, good);
      cut = ($urandom_range(0, 4) == 0) ? $urandom_range(0, fq.size() - 1) : fq.size();
      while (fq.size() > cut) void'(fq.pop_back());
      start_load();
      send_bytes(fq, $urandom_range(30, 100));
      if (cut == fq.size() && model_status(cur_frame) != M_BUSY) begin
        check_status("rand");
      end
      fetch_check();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Instruction-memory front end for the single-cycle MIPS core, sitting directly upstream of the CPU's `pc`/`instr` fetch port. It receives a program image over a byte-wide valid/ready stream, assembles little-endian 32-bit words, and writes them into an internal instruction RAM. While loading, it holds the CPU in reset. Once the image is complete, it releases the CPU and serves instruction fetches combinationally.

## Interface
Parameters:
- `DEPTH`, 64: instruction RAM size in 32-bit words; must be a power of two, at least 2.
- `ADDR_W`, $clog2(DEPTH): word-address width (derived; do not override).

Ports:
- `clk`  in  1  single clock.
- `reset`  in  1  synchronous, active-high reset.
- `load_start`  in  1  single-cycle pulse; begins or restarts a load.
- `rx_data`  in  8  stream byte.
- `rx_valid`  in  1  `rx_data` is valid.
- `rx_ready`  out  1  loader can accept a byte this cycle.
- `pc`  in  32  CPU fetch address.
- `instr`  out  32  instruction at `pc`.
- `cpu_reset`  out  1  drives the CPU `reset`; high unless in RUN.
- `load_done`  out  1  high in RUN.
- `load_err`  out  1  high in ERR.

## Operation
- Handshake: a byte is accepted on a rising edge where `rx_valid & rx_ready`. `rx_valid` may drop at any time; bytes presented while `rx_ready` is 0 are not consumed.
- Frame format:
  - 2-byte word count N, little-endian.
  - N×4 payload bytes; byte k of a word goes to bits [8k+7:8k].
  - With IMEM_CHECKSUM_EN only: 1 checksum byte.
- States:
  - IDLE: `cpu_reset`=1, `rx_ready`=0. `load_start` → LEN0.
  - LEN0: `rx_ready`=1. Accepted byte → N[7:0], then → LEN1.
  - LEN1: `rx_ready`=1. Accepted byte → N[15:8].
    - If N > DEPTH → ERR.
    - If N==0 → RUN (or CSUM if enabled).
    - Otherwise → DATA.
  - DATA: `rx_ready`=1. Each accepted byte advances a 2-bit byte counter.
    - On the 4th byte, the assembled word is written to RAM[word_idx] on that same edge, and word_idx increments.
    - After word N-1 → RUN (or CSUM if enabled).
  - CSUM: `rx_ready`=1. Accepted byte is compared with the running checksum: equal → RUN, else → ERR.
  - RUN: `cpu_reset`=0, `load_done`=1, `rx_ready`=0.
  - ERR: `cpu_reset`=1, `load_err`=1, `rx_ready`=0.
- `load_start` in any state (including mid-load, RUN, ERR): next state is LEN0.
  - word_idx, byte counter and checksum clear.
  - RAM contents are retained.
  - `cpu_reset` is 1 from the next edge.
  - `load_start` has priority over a byte accepted on the same edge; that byte is discarded.
- Fetch: `instr` = RAM[`pc`[ADDR_W+1:2]], a combinational read in every state.
  - `pc`[1:0] and bits above ADDR_W+1 are ignored, so addresses wrap modulo DEPTH words.
  - RAM is not cleared by reset; unwritten words read as undefined.

## Timing
- Reset values: state=IDLE, `cpu_reset`=1, `rx_ready`=0, `load_done`=0, `load_err`=0; word_idx, byte counter and checksum = 0.
- All outputs except `instr` are registered or decoded from state only. There is no combinational path from `rx_valid` to `rx_ready`.
- A word written on edge t is visible on `instr` from edge t onward.
- `cpu_reset` falls on the same edge that accepts the final byte, so the CPU's first un-reset edge is the following edge with `pc`=0.
- One byte per cycle at most; a full load takes at least 2+4N (+1) cycles after `load_start`.

## Configuration
- `IMEM_CHECKSUM_EN` defined:
  - The CSUM state exists.
  - The checksum is the XOR of all payload bytes; the length bytes are excluded.
  - A mismatch → ERR.
- Not defined:
  - No CSUM state and no checksum register.
  - ERR is reachable only via N > DEPTH.

## Structure
- `imem_loader_pkg`: state enum (IDLE, LEN0, LEN1, DATA, CSUM, RUN, ERR), `BYTES_PER_WORD`=4, `LEN_BYTES`=2.
- Sub-module `imem_ram`: DEPTH×32 memory with one synchronous write port (`we`, `waddr`, `wdata`) and one asynchronous read port. It has no reset.

## Test plan
- Reset → `cpu_reset`=1, `rx_ready`=0, `load_done`=0, `load_err`=0, for 5 cycles with `rx_valid`=1.
- `load_start`, then bytes 02 00 20 00 08 20 05 00 09 20 → RAM[0]=0x20080020, RAM[1]=0x20090005.
  - `cpu_reset` falls on the edge accepting the last byte.
  - `pc`=4 gives `instr`=0x20090005; `pc`=0x104 gives 0x20090005 (wrap, DEPTH=64).
- Same stream with `rx_valid` toggled every other cycle → identical RAM contents and final state; no byte is duplicated or dropped.
- Length bytes 41 00 (N=65, DEPTH=64) → ERR after the 2nd byte, `load_err`=1, `rx_ready`=0, `cpu_reset`=1. A new `load_start` → LEN0 and `load_err`=0.
- With `IMEM_CHECKSUM_EN`, the load from the second scenario plus checksum 0x24 → RUN. With checksum 0x25 → ERR.
- `load_start` after the 6th payload byte, followed by a full 1-word frame 01 00 AA BB CC DD:
  - RAM[0]=0xDDCCBBAA; RAM[1] is unchanged.
  - `cpu_reset` stays 1 until that frame completes.
